// File: rtl/llc_dma_requester_pkg.sv
// llc_dma_requester_pkg: shared line/address types and DMA coherence message encodings.
package llc_dma_requester_pkg;
    localparam int LINE_ADDR_BITS = 12;
    localparam int BITS_PER_LINE = 32;
    localparam int CNT_BITS = 4;
    typedef logic [LINE_ADDR_BITS-1:0] line_addr_t;
    typedef logic [BITS_PER_LINE-1:0] line_t;
    typedef logic [1:0] coh_msg_t;
    localparam coh_msg_t REQ_DMA_READ = 2'd1;
    localparam coh_msg_t REQ_DMA_WRITE = 2'd2;
endpackage

// File: rtl/llc_dma_credit_counter.sv
// llc_dma_credit_counter: outstanding-request counter; a decrement at zero is dropped.
module llc_dma_credit_counter
    import llc_dma_requester_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                inc,
    input  logic                dec,
    output logic [CNT_BITS-1:0] count,
    output logic                full,
    output logic                empty_next
);
    logic [CNT_BITS-1:0] count_d;
    assign count_d = clr ? '0 : count + CNT_BITS'(inc) - CNT_BITS'(dec && count != '0);
    assign full = count >= CNT_BITS'(MAX);
    assign empty_next = count_d == '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count <= '0;
        else count <= count_d;
    end
endmodule

// File: rtl/llc_dma_requester.sv
// llc_dma_requester: line-granular DMA initiator driving the LLC DMA request/response channels.
// Defining LLC_DMA_REQ_WATCHDOG_EN adds a stall watchdog and the watchdog_err output.
module llc_dma_requester
    import llc_dma_requester_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int LEN_BITS = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      desc_valid,
    output logic                      desc_ready,
    input  logic [LINE_ADDR_BITS-1:0] desc_addr,
    input  logic [LEN_BITS-1:0]       desc_len,
    input  logic                      desc_write,
    input  logic                      wr_data_valid,
    output logic                      wr_data_ready,
    input  logic [BITS_PER_LINE-1:0]  wr_data,
    output logic                      llc_dma_req_valid,
    input  logic                      llc_dma_req_ready,
    output logic [1:0]                llc_dma_req_coh_msg,
    output logic [LINE_ADDR_BITS-1:0] llc_dma_req_addr,
    output logic [BITS_PER_LINE-1:0]  llc_dma_req_line,
    input  logic                      llc_dma_rsp_valid,
    output logic                      llc_dma_rsp_ready,
    input  logic [BITS_PER_LINE-1:0]  llc_dma_rsp_line,
    output logic                      rd_data_valid,
    input  logic                      rd_data_ready,
    output logic [BITS_PER_LINE-1:0]  rd_data,
`ifdef LLC_DMA_REQ_WATCHDOG_EN
    output logic                      watchdog_err,
`endif
    output logic                      done,
    output logic                      busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t state, state_d;
    line_addr_t addr;
    logic [LEN_BITS-1:0] len, issued;
    logic [CNT_BITS-1:0] outstanding;
    logic write, active, desc_fire, req_fire, rsp_fire, full, empty_d, clr;

    assign active = state == ISSUE || state == DRAIN;
    assign desc_ready = state == IDLE;
    assign busy = state != IDLE;
    assign done = state == DONE;
    assign desc_fire = desc_valid && desc_ready;
    assign llc_dma_req_valid = state == ISSUE && !full && (!write || wr_data_valid);
    assign req_fire = llc_dma_req_valid && llc_dma_req_ready;
    assign wr_data_ready = req_fire && write;
    assign llc_dma_req_coh_msg = state == ISSUE ? (write ? REQ_DMA_WRITE : REQ_DMA_READ) : '0;
    assign llc_dma_req_addr = addr;
    assign llc_dma_req_line = llc_dma_req_valid && write ? wr_data : '0;
    assign llc_dma_rsp_ready = active && (write || rd_data_ready);
    assign rsp_fire = llc_dma_rsp_valid && llc_dma_rsp_ready;
    // A response with nothing outstanding is a stray and never reaches the client.
    assign rd_data_valid = active && !write && llc_dma_rsp_valid && outstanding != '0;
    assign rd_data = rd_data_valid ? llc_dma_rsp_line : '0;

`ifdef LLC_DMA_REQ_WATCHDOG_EN
    logic [15:0] wd_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wd_cnt <= '0;
        else if (req_fire || rsp_fire || watchdog_err) wd_cnt <= '0;
        else if (outstanding != '0) wd_cnt <= wd_cnt + 16'd1;
    end
    assign watchdog_err = wd_cnt == 16'hFFFF;
    assign clr = watchdog_err;
`else
    assign clr = 1'b0;
`endif

    llc_dma_credit_counter #(.MAX(MAX_OUTSTANDING)) u_credit (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .inc       (req_fire),
        .dec       (rsp_fire),
        .count     (outstanding),
        .full      (full),
        .empty_next(empty_d)
    );

    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (desc_fire) state_d = desc_len == '0 ? DONE : ISSUE;
            ISSUE: if (req_fire && issued + LEN_BITS'(1) == len) state_d = DRAIN;
            DRAIN: if (empty_d) state_d = DONE;
            default: state_d = IDLE;
        endcase
        if (clr) state_d = DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            addr <= '0;
            len <= '0;
            issued <= '0;
            write <= 1'b0;
        end else begin
            state <= state_d;
            if (desc_fire) begin
                addr <= desc_addr;
                len <= desc_len;
                issued <= '0;
                write <= desc_write;
            end else if (req_fire) begin
                addr <= addr + LINE_ADDR_BITS'(1);
                issued <= issued + LEN_BITS'(1);
            end
        end
    end
endmodule

// File: tb/tb_llc_dma_requester.sv
// tb_llc_dma_requester: directed bursts against a transaction-level model of the requester and an LLC responder.
module tb_llc_dma_requester;
    import llc_dma_requester_pkg::*;
    localparam int MAX = 4;
    localparam int RSP_LAT = 2;

    logic clk = 1'b0, rst_n = 1'b1;
    logic desc_valid = 0, desc_write = 0, wr_data_valid = 0, llc_dma_req_ready = 1;
    logic llc_dma_rsp_valid = 0, rd_data_ready = 1;
    logic [LINE_ADDR_BITS-1:0] desc_addr = '0;
    logic [15:0] desc_len = '0;
    logic [BITS_PER_LINE-1:0] wr_data = '0, llc_dma_rsp_line = '0;
    logic desc_ready, wr_data_ready, llc_dma_req_valid, llc_dma_rsp_ready, rd_data_valid, done, busy;
    logic [1:0] llc_dma_req_coh_msg;
    logic [LINE_ADDR_BITS-1:0] llc_dma_req_addr;
    logic [BITS_PER_LINE-1:0] llc_dma_req_line, rd_data;
    logic [6:0] ctrl;

    llc_dma_requester #(.MAX_OUTSTANDING(MAX), .LEN_BITS(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_addr(desc_addr),
        .desc_len(desc_len), .desc_write(desc_write),
        .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready), .wr_data(wr_data),
        .llc_dma_req_valid(llc_dma_req_valid), .llc_dma_req_ready(llc_dma_req_ready),
        .llc_dma_req_coh_msg(llc_dma_req_coh_msg), .llc_dma_req_addr(llc_dma_req_addr),
        .llc_dma_req_line(llc_dma_req_line),
        .llc_dma_rsp_valid(llc_dma_rsp_valid), .llc_dma_rsp_ready(llc_dma_rsp_ready),
        .llc_dma_rsp_line(llc_dma_rsp_line),
        .rd_data_valid(rd_data_valid), .rd_data_ready(rd_data_ready), .rd_data(rd_data),
        .done(done), .busy(busy)
    );

    assign ctrl = {desc_ready, busy, done, llc_dma_req_valid, wr_data_ready, llc_dma_rsp_ready, rd_data_valid};
    always #5 clk = ~clk;

    int passed = 0, total = 0, cyc = 0;
    // environment: LLC responder, write stream, descriptor source
    line_addr_t llc_q[$], req_log[$];
    int due_q[$];
    line_t wq[$], line_log[$];
    int hold_until = 0, desc_cyc = 0, first_req_cyc = 0, last_req_cyc = 0, last_rsp_cyc = 0;
    int done_cnt = 0, done_cyc = 0, rd_cnt = 0;
    logic desc_pend = 0, wr_gap = 0, stray = 0;
    // requester model: burst in flight, lines left to issue, lines awaiting response
    logic m_busy = 0, m_done = 0, m_wr = 0;
    int m_rem = 0, m_out = 0;
    line_addr_t m_addr = '0;
    line_addr_t exp_rd[$];

    function automatic line_t mkline(input line_addr_t a);
        return {20'hA5A50, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        else passed++;
    endtask

    task automatic step();
        logic q_rdy, act, e_req, e_rsp_rdy, e_rd, rq, rs, df;
        int o;
        @(negedge clk);
        cyc++;
        desc_valid = desc_pend;
        wr_data_valid = wq.size() > 0 && (!wr_gap || cyc % 2 == 0);
        wr_data = wq.size() > 0 ? wq[0] : '0;
        q_rdy = llc_q.size() > 0 && due_q[0] <= cyc && cyc >= hold_until;
        llc_dma_rsp_valid = q_rdy || stray;
        llc_dma_rsp_line = q_rdy ? mkline(llc_q[0]) : 32'hDEAD_BEEF;
        act = m_busy && !m_done;
        e_req = act && m_rem > 0 && m_out < MAX && (!m_wr || wr_data_valid);
        e_rsp_rdy = act && (m_wr || rd_data_ready);
        e_rd = act && !m_wr && llc_dma_rsp_valid && m_out > 0;
        #2;
        chk("ctrl", 64'(ctrl), 64'({!m_busy, m_busy, m_done, e_req, e_req && llc_dma_req_ready && m_wr, e_rsp_rdy, e_rd}));
        if (e_req) begin
            chk("req_addr", 64'(llc_dma_req_addr), 64'(m_addr));
            chk("req_msg", 64'(llc_dma_req_coh_msg), 64'(m_wr ? REQ_DMA_WRITE : REQ_DMA_READ));
            chk("req_line", 64'(llc_dma_req_line), 64'(m_wr ? wq[0] : '0));
        end
        if (e_rd) chk("rd_data", 64'(rd_data), 64'(mkline(exp_rd[0])));
        rq = llc_dma_req_valid && llc_dma_req_ready;
        rs = llc_dma_rsp_valid && llc_dma_rsp_ready;
        df = desc_valid && desc_ready;
        if (rq) begin
            req_log.push_back(llc_dma_req_addr);
            line_log.push_back(llc_dma_req_line);
            llc_q.push_back(llc_dma_req_addr);
            due_q.push_back(cyc + RSP_LAT);
            if (req_log.size() == 1) first_req_cyc = cyc;
            last_req_cyc = cyc;
        end
        if (wr_data_valid && wr_data_ready) void'(wq.pop_front());
        if (rs && q_rdy) begin
            void'(llc_q.pop_front());
            void'(due_q.pop_front());
            last_rsp_cyc = cyc;
        end else if (rs) stray = 0;
        if (rd_data_valid && rd_data_ready) rd_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (df) begin
            desc_pend = 0;
            desc_cyc = cyc;
            m_busy = 1;
            m_wr = desc_write;
            m_rem = int'(desc_len);
            m_addr = desc_addr;
            m_out = 0;
            m_done = desc_len == 0;
        end else if (m_done) begin
            m_done = 0;
            m_busy = 0;
        end else if (m_busy) begin
            o = m_out;
            if (rq) begin
                if (!m_wr) exp_rd.push_back(m_addr);
                m_rem--;
                m_addr++;
                m_out++;
            end
            if (rs && o > 0) begin
                m_out--;
                if (!m_wr) void'(exp_rd.pop_front());
            end
            if (m_rem == 0 && m_out == 0) m_done = 1;
        end
    endtask

    task automatic start(input line_addr_t a, input int len, input logic w);
        desc_addr = a;
        desc_len = 16'(len);
        desc_write = w;
        desc_pend = 1;
        done_cnt = 0;
        rd_cnt = 0;
        req_log.delete();
        line_log.delete();
        if (w) for (int i = 0; i < len; i++) wq.push_back(32'hC0DE_0000 + 32'(i));
    endtask

    task automatic run_done(input int budget);
        int i = 0;
        while (done_cnt == 0 && i < budget) begin
            step();
            i++;
        end
        chk("done_seen", 64'(done_cnt), 1);
        step();
        step();
        chk("done_once", 64'(done_cnt), 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        desc_pend = 0;
        desc_valid = 0;
        wr_data_valid = 0;
        stray = 1;
        llc_dma_rsp_valid = 1;
        llc_dma_rsp_line = 32'hDEAD_BEEF;
        llc_q.delete();
        due_q.delete();
        wq.delete();
        exp_rd.delete();
        m_busy = 0;
        m_done = 0;
        m_out = 0;
        m_rem = 0;
        #1;
        chk("rst_ctrl", 64'(ctrl), 64'(7'b1000000));
        chk("rst_req", 64'({llc_dma_req_coh_msg, llc_dma_req_addr, llc_dma_req_line}), 0);
        step();
        step();
        rst_n = 1;
        step();
        chk("stray_held_idle", 64'(stray), 1);
    endtask

    initial begin
        #1 rst_n = 0;
        #1 chk("reset_ctrl", 64'(ctrl), 64'(7'b1000000));
        chk("reset_req", 64'({llc_dma_req_coh_msg, llc_dma_req_addr, llc_dma_req_line, rd_data}), 0);
        step();
        rst_n = 1;
        step();
        // read burst, back-to-back issue, responses two cycles later
        start(12'h100, 4, 0);
        run_done(40);
        chk("rd_addr0", 64'(req_log[0]), 64'h100);
        chk("rd_addr3", 64'(req_log[3]), 64'h103);
        chk("rd_first_lat", 64'(first_req_cyc - desc_cyc), 1);
        chk("rd_b2b", 64'(last_req_cyc - first_req_cyc), 3);
        chk("rd_beats", 64'(rd_cnt), 4);
        chk("rd_done_lat", 64'(done_cyc - last_rsp_cyc), 1);
        // write burst with gapped write data
        wr_gap = 1;
        start(12'h010, 3, 1);
        run_done(40);
        wr_gap = 0;
        chk("wr_reqs", 64'(req_log.size()), 3);
        chk("wr_addr0", 64'(req_log[0]), 64'h010);
        chk("wr_line2", 64'(line_log[2]), 64'hC0DE_0002);
        chk("wr_no_rd", 64'(rd_cnt), 0);
        // credit limit: LLC silent for 20 cycles
        start(12'h080, 8, 0);
        hold_until = cyc + 20;
        repeat (15) step();
        chk("credit_cap", 64'(req_log.size()), 4);
        run_done(80);
        chk("credit_total", 64'(req_log.size()), 8);
        chk("credit_beats", 64'(rd_cnt), 8);
        // zero-length descriptor
        start(12'h300, 0, 0);
        run_done(10);
        chk("len0_lat", 64'(done_cyc - desc_cyc), 1);
        chk("len0_reqs", 64'(req_log.size()), 0);
        // address wrap
        start(12'hFFF, 2, 0);
        run_done(20);
        chk("wrap_a0", 64'(req_log[0]), 64'hFFF);
        chk("wrap_a1", 64'(req_log[1]), 64'h000);
        // reset after two of six requests, then a stray response and a fresh burst
        start(12'h040, 6, 0);
        hold_until = cyc + 50;
        for (int i = 0; i < 20 && req_log.size() < 2; i++) step();
        chk("pre_rst_reqs", 64'(req_log.size()), 2);
        do_reset();
        hold_until = 0;
        start(12'h200, 3, 0);
        run_done(40);
        chk("stray_dropped", 64'(stray), 0);
        chk("post_rst_reqs", 64'(req_log.size()), 3);
        chk("post_rst_beats", 64'(rd_cnt), 3);
        chk("post_rst_addr", 64'(req_log[0]), 64'h200);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
